contador_ad_bcd_param: RTL

CONTADOR_AD_BCD_PARAM -- requirements
Module: contador_ad_bcd_param

---
 rtl/contador_ad_bcd_param_pkg.sv | 16 +
 rtl/bin2bcd_2dig.sv | 25 ++
 rtl/contador_ad_bcd_param.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/contador_ad_bcd_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : contador_ad_bcd_param_pkg
//  Purpose  : Shared button-FSM state encodings for the BCD field counters.
//  Revision : 1.0  initial release
// ============================================================================
package contador_ad_bcd_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

endpackage : contador_ad_bcd_param_pkg
`default_nettype wire

// File: rtl/bin2bcd_2dig.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_2dig
//  Purpose  : Combinational 7-bit binary to two BCD digits (tens, units).
//  Revision : 1.0  initial release
// ============================================================================
module bin2bcd_2dig (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] units
);

    // Threshold ladder instead of a divider; inputs above 99 are never fed in.
    always_comb begin
        tens = 4'd0;
        for (int t = 1; t < 10; t++) begin
            if (bin >= 7'(t * 10)) begin
                tens = 4'(t);
            end
        end
        units = 4'(bin - (7'(tens) * 7'd10));
    end

endmodule : bin2bcd_2dig
`default_nettype wire

// File: rtl/contador_ad_bcd_param.sv
`default_nettype none
// ============================================================================
//  Module   : contador_ad_bcd_param
//  Purpose  : Parameterised up/down BCD field counter with tap-step,
//             hold-delay auto-repeat, range-checked load and wrap pulses.
//  Revision : 1.0  initial release
// ============================================================================
module contador_ad_bcd_param
    import contador_ad_bcd_param_pkg::*;
#(
    parameter int MIN_VAL  = 0,
    parameter int MAX_VAL  = 59,
    parameter int SEL_CODE = 9,
    parameter int TICK_DIV = 12_500_000,
    parameter int HOLD_DLY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] en_count,
    input  logic       enUP,
    input  logic       enDOWN,
    input  logic       load,
    input  logic [6:0] load_val,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       carry,
    output logic       borrow
);

    localparam int                  c_TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int                  c_HOLD_W    = (HOLD_DLY > 1) ? $clog2(HOLD_DLY) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_DLY - 1);
    localparam logic [6:0]          c_MIN       = 7'(MIN_VAL);
    localparam logic [6:0]          c_MAX       = 7'(MAX_VAL);

    logic [6:0]          r_q;
    btn_state_t          r_state;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_up_q;
    logic                r_dn_q;
    logic                r_run;
    logic                r_dir_up;

    logic w_active;
    logic w_tick;
    logic w_up_rise;
    logic w_dn_rise;
    logic w_press;
    logic w_held;
    logic w_enter_wait;
    logic w_load_ok;
    logic w_step;
    logic w_step_up;

    assign w_active  = (en_count == 4'(SEL_CODE));
    assign w_tick    = (r_tick_cnt == c_TICK_LAST);

    // r_run masks the first cycle after reset so a button held through
    // reset only reloads its registered copy instead of looking like a press.
    assign w_up_rise = enUP   & ~r_up_q & r_run;
    assign w_dn_rise = enDOWN & ~r_dn_q & r_run;

    assign w_press      = w_active & (enUP ^ enDOWN) & (w_up_rise | w_dn_rise);
    assign w_held       = w_active & (enUP ^ enDOWN) & (r_dir_up ? enUP : enDOWN);
    assign w_enter_wait = (r_state == ST_IDLE) & w_press & ~load;
    assign w_load_ok    = (int'(load_val) >= MIN_VAL) && (int'(load_val) <= MAX_VAL);

    always_comb begin
        w_step    = 1'b0;
        w_step_up = r_dir_up;
        unique case (r_state)
            ST_IDLE: begin
                w_step    = w_press;
                w_step_up = enUP;
            end
            ST_WAIT:   w_step = 1'b0;
            ST_REPEAT: w_step = w_held & w_tick;
            default:   w_step = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_up_q <= 1'b0;
            r_dn_q <= 1'b0;
            r_run  <= 1'b0;
        end else begin
            r_up_q <= enUP;
            r_dn_q <= enDOWN;
            r_run  <= 1'b1;
        end
    end

    // Free-running divider, realigned so the first tick lands a full
    // period after the press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_enter_wait || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_dir_up   <= 1'b0;
        end else if (load) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        r_state    <= ST_WAIT;
                        r_dir_up   <= enUP;
                        r_hold_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (!w_held) begin
                        r_state <= ST_IDLE;
                    end else if (w_tick) begin
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            r_state    <= ST_REPEAT;
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (!w_held) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q    <= c_MIN;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else begin
            carry  <= 1'b0;
            borrow <= 1'b0;
            if (load) begin
                if (w_load_ok) begin
                    r_q <= load_val;
                end
            end else if (w_step) begin
                if (w_step_up) begin
                    if (r_q == c_MAX) begin
                        r_q   <= c_MIN;
                        carry <= 1'b1;
                    end else begin
                        r_q <= r_q + 7'd1;
                    end
                end else begin
                    if (r_q == c_MIN) begin
                        r_q    <= c_MAX;
                        borrow <= 1'b1;
                    end else begin
                        r_q <= r_q - 7'd1;
                    end
                end
            end
        end
    end

    bin2bcd_2dig u_bcd (
        .bin   (r_q),
        .tens  (digit1),
        .units (digit0)
    );

endmodule : contador_ad_bcd_param
`default_nettype wire
